// File: rtl/config_stream_loader.sv
// Serial-to-word loader for the connection-block configuration chain.
// Frames are SYNC_BYTE, NUM_BLOCKS payload words, then an XOR checksum byte, all MSB-first.
module config_stream_loader #(
  parameter int         NUM_BLOCKS = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ser_valid,
  input  logic       ser_data,
  output logic       ser_ready,
  output logic [7:0] cfg_data,
  output logic       cfg_shift,
  output logic [7:0] word_count,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error
);

  localparam logic [7:0] NB = 8'(NUM_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOAD, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t     state, state_next;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] checksum;
  logic       accept;
  logic       byte_done;
  logic       start_ok;
  logic [7:0] byte_now;

  assign accept    = ser_valid && ser_ready;
  assign byte_now  = {shreg[6:0], ser_data};
  assign byte_done = accept && (bit_cnt == 3'd7);
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps unlisted paths from inferring latches.
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start) state_next = S_HEADER;
      S_HEADER:
        if (byte_done) state_next = (byte_now == SYNC_BYTE) ? S_LOAD : S_ERROR;
      S_LOAD:
        if (byte_done && word_count == NB - 8'd1) state_next = S_CHECK;
      S_CHECK:
        if (byte_done) state_next = (byte_now == checksum) ? S_DONE : S_ERROR;
      default:
        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ser_ready = 1'b0;
    cfg_busy  = 1'b0;
    case (state)
      S_HEADER, S_LOAD, S_CHECK: begin
        ser_ready = 1'b1;
        cfg_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      checksum   <= '0;
      cfg_data   <= '0;
      cfg_shift  <= 1'b0;
      word_count <= '0;
      cfg_done   <= 1'b0;
      cfg_error  <= 1'b0;
    end else begin
      cfg_shift <= 1'b0;
      if (start_ok || state == S_IDLE) begin
        bit_cnt    <= '0;
        shreg      <= '0;
        checksum   <= '0;
        word_count <= '0;
        cfg_done   <= 1'b0;
        cfg_error  <= 1'b0;
      end else if (accept) begin
        // The 3-bit counter wraps to 0 on its own after the 8th bit.
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= byte_now;
        if (byte_done) begin
          case (state)
            S_HEADER:
              if (byte_now != SYNC_BYTE) cfg_error <= 1'b1;
            S_LOAD: begin
              cfg_data  <= byte_now;
              cfg_shift <= 1'b1;
              checksum  <= checksum ^ byte_now;
              if (word_count != NB) word_count <= word_count + 8'd1;
            end
            S_CHECK:
              if (byte_now == checksum) cfg_done  <= 1'b1;
              else                      cfg_error <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Upstream feeder for the connection-block configuration chain.
- Receives a framed serial bitstream over a valid/ready handshake and assembles it into 8-bit configuration words.
- Presents each word on cfg_data with a one-cycle cfg_shift strobe, so NUM_BLOCKS connection blocks are loaded in chain order.
- Checks a sync header and an XOR checksum, then reports done or error.

Parameters:
- NUM_BLOCKS, 4, number of 8-bit configuration words in one frame (range 1..255).
- SYNC_BYTE, 8'hA5, required first byte of every frame.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE, DONE or ERROR.
- ser_valid  in  1  ser_data is valid this cycle.
- ser_data  in  1  serial bit, MSB-first within each byte.
- ser_ready  out  1  loader accepts a bit this cycle.
- cfg_data  out  8  last completed payload word; held between strobes.
- cfg_shift  out  1  one-cycle strobe: cfg_data holds a new word.
- word_count  out  8  number of payload words strobed in the current frame.
- cfg_busy  out  1  high in HEADER, LOAD and CHECK.
- cfg_done  out  1  frame loaded and checksum matched; sticky until start or reset.
- cfg_error  out  1  sync or checksum failure; sticky until start or reset.

Behaviour:
- Reset: state=IDLE. The following are all 0: ser_ready, cfg_data, cfg_shift, word_count, cfg_busy, cfg_done, cfg_error, bit counter, shift register, checksum accumulator.
- A bit is accepted only on a cycle with ser_valid && ser_ready. ser_ready is combinational from state: 1 in HEADER, LOAD and CHECK; 0 otherwise.
- A 3-bit counter tracks accepted bits. An 8-bit shift register shifts left and takes ser_data into the LSB. The byte is complete on the 8th accepted bit, after which the counter wraps to 0.
- IDLE:
  - start -> HEADER.
  - Clear word_count, checksum, bit counter, cfg_done and cfg_error.
- HEADER (8 bits received):
  - Byte == SYNC_BYTE -> LOAD.
  - Otherwise -> ERROR.
- LOAD (completed byte):
  - Register byte into cfg_data and pulse cfg_shift on the next cycle. Latency is 1 clock from the accepting edge of the 8th bit.
  - Increment word_count.
  - XOR byte into the checksum.
  - When word_count reaches NUM_BLOCKS -> CHECK; else stay in LOAD.
- CHECK (completed byte):
  - Byte == checksum -> DONE with cfg_done=1.
  - Otherwise -> ERROR with cfg_error=1.
  - The flag asserts on the cycle after the 8th checksum bit.
  - The checksum byte is never strobed out on cfg_shift.
- DONE / ERROR:
  - ser_ready=0 and flags held.
  - start -> HEADER and clears both flags, the counters and the checksum.
  - cfg_data retains its last value.
- start in HEADER, LOAD or CHECK is ignored; the frame continues.
- ser_valid gaps (ser_valid=0) stall the counters with no timeout. Partial-byte state is held indefinitely.
- Reset asserted mid-frame: next cycle is IDLE with all outputs at reset values. A partially received word is discarded and no cfg_shift is issued.
- Reset and start in the same cycle: reset wins.
- cfg_shift is never high on two consecutive cycles. Minimum spacing is 8 cycles at full ser_valid rate.
- Total frame length is 8*(NUM_BLOCKS+2) accepted bits.
- word_count saturates at NUM_BLOCKS.

Test Plan:
- Nominal frame:
  - Stimulus: NUM_BLOCKS=4, continuous ser_valid, bits A5, 1B, E4, 00, FF, checksum 00.
  - Response: cfg_shift pulses exactly 4 times with cfg_data=1B, E4, 00, FF, spaced 8 cycles apart. cfg_done=1 one cycle after bit 48. ser_ready=0 afterwards.
- Bad sync:
  - Stimulus: header byte 5A.
  - Response: cfg_error=1 one cycle after bit 8, no cfg_shift, ser_ready=0, cfg_done=0.
- Bad checksum:
  - Stimulus: same payload as the nominal frame, checksum byte 01.
  - Response: 4 strobes, then cfg_error=1, cfg_done=0.
- Stalled input:
  - Stimulus: nominal frame with ser_valid toggling 1,0,0,1 randomly.
  - Response: identical cfg_data sequence and result. Strobes occur only one cycle after each 8th accepted bit.
- Reset mid-frame:
  - Stimulus: reset asserted after 5 bits of the second payload byte, then a new nominal frame.
  - Response: all outputs return to 0 the next cycle. The new frame produces exactly 4 correct strobes and cfg_done=1.
- Restart and ignored start:
  - Stimulus: start pulsed during LOAD, then start pulsed from ERROR.
  - Response: the first start has no effect on the frame. The second clears cfg_error on the next cycle and returns to HEADER with ser_ready=1.
